alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  ID->EX operand stage feeding the ALU (src1_i/src2_i/ctrl_i).
//  Registers decoded instruction fields and forms final ALU operands:
//   - forwarding
//   - immediate extension
//   - ALUSrc mux
//  Two-entry (output + skid) buffer with valid/ready handshake on both sides, so ALU-side
//  stalls never drop an instruction.
// PARAMETERS
//  DATA_W  32  operand/result width
//  IMM_W   16  raw immediate width, extended to DATA_W
//  CTRL_W  4   ALU control width (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR)
//  REG_AW  5   register address width
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  flush_i      in   1       sync flush (branch taken), clears both entries
//  in_valid_i   in   1       ID presents an instruction
//  in_ready_o   out  1       stage can accept (registered)
//  rs_data_i    in   DATA_W  register-file read of rs
//  rt_data_i    in   DATA_W  register-file read of rt
//  rs_addr_i    in   REG_AW  rs index
//  rt_addr_i    in   REG_AW  rt index
//  imm_i        in   IMM_W   raw immediate
//  zext_i       in   1       1 = zero-extend imm, 0 = sign-extend
//  alusrc_i     in   1       1 = src2 from imm, 0 = from rt
//  ctrl_i       in   CTRL_W  ALU control
//  rd_i         in   REG_AW  destination register
//  wr_i         in   1       instruction writes rd
//  exmem_wr_i   in   1       EX/MEM stage writes back
//  exmem_rd_i   in   REG_AW  EX/MEM destination
//  exmem_data_i in   DATA_W  EX/MEM result
//  memwb_wr_i   in   1       MEM/WB stage writes back
//  memwb_rd_i   in   REG_AW  MEM/WB destination
//  memwb_data_i in   DATA_W  MEM/WB result
//  out_valid_o  out  1       operands valid to ALU
//  out_ready_i  in   1       EX consumes
//  src1_o       out  DATA_W  ALU operand 1
//  src2_o       out  DATA_W  ALU operand 2
//  ctrl_o       out  CTRL_W  ALU control
//  rd_o         out  REG_AW  destination, passed through
//  wr_o         out  1       write enable, passed through
// BEHAVIOUR
//  Reset: all outputs 0, in_ready_o=1, state EMPTY.
//  accept = in_valid_i & in_ready_o.
//  take   = out_valid_o & out_ready_i.
//  Operands formed combinationally from inputs and captured on accept (latency 1 cycle).
//  fwd(a,d):
//   - a==0 -> d
//   - exmem_wr_i & exmem_rd_i==a -> exmem_data_i
//   - memwb_wr_i & memwb_rd_i==a -> memwb_data_i
//   - else d
//   - EX/MEM has priority over MEM/WB.
//  src1 = fwd(rs). src2 = alusrc_i ? ext(imm_i) : fwd(rt).
//  ext: sign- or zero-extend per zext_i.
//  Entries are not re-forwarded after capture; the hazard unit owns load-use stalls.
//  States, set by out and skid valid bits:
//   - EMPTY: accept -> ONE.
//   - ONE: accept & ~take -> FULL (new item in skid).
//   - ONE: accept & take -> ONE (new item in out).
//   - ONE: take & ~accept -> EMPTY.
//   - ONE: else hold.
//   - FULL: take -> ONE (skid moves to out, same edge). in_ready_o=0, so no accept.
//  in_ready_o = ~skid_valid (registered, never combinational from out_ready_i).
//  Outputs hold stable while out_valid_o & ~out_ready_i.
//  flush_i: next state EMPTY. Wins over accept/take in the same cycle; the input is dropped.
//  Data regs may keep stale values when invalid. rd_o/wr_o clear to 0 on flush.
//  Reset mid-operation: immediate return to reset values; no pending item survives.
//  Order is strict FIFO; no reordering, no duplication.
// CONFIGURATION
//  ALU_OPS_FWD_EN defined: forwarding as above.
//  ALU_OPS_FWD_EN undefined: fwd(a,d)=d. exmem_* and memwb_* are ignored (ports kept).
// TESTING
//  1 Reset low mid-stream -> out_valid_o=0, in_ready_o=1, src1_o=0 in same cycle.
//  2 rs=3 data 5, rt=4 data 7, alusrc=0, ctrl=2, out_ready=1 -> next cycle src1=5 src2=7 ctrl=2 valid=1.
//  3 imm=16'hFFFE, zext=0, alusrc=1 -> src2=32'hFFFFFFFE; zext=1 -> src2=32'h0000FFFE.
//  4 FWD_EN: rs=8, exmem_wr=1 rd=8 data=0xAA, memwb rd=8 data=0xBB -> src1=0xAA.
//    Repeat with rs=0 -> src1=rs_data_i.
//  5 out_ready=0, push A,B -> in_ready_o=0 after B, A held.
//    Raise out_ready -> A then B on consecutive cycles, no loss.
//  6 FULL with flush_i=1 and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, input dropped.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID->EX operand stage; forwards rs/rt, extends the immediate, muxes ALUSrc.
// Latency: 1 cycle from accept to out_valid_o; an output entry plus a skid entry hold two items.
// Backpressure: in_ready_o drops only when the skid entry is occupied, so it is purely registered.
//
// Ports:
//   clk_i, rst_i (async active-low), flush_i (sync, clears both entries)
//   in_valid_i/in_ready_o      : ID-side handshake
//   rs/rt data+addr, imm_i, zext_i, alusrc_i, ctrl_i, rd_i, wr_i : decoded fields
//   exmem_*/memwb_*            : writeback sources for operand forwarding
//   out_valid_o/out_ready_i    : EX-side handshake
//   src1_o, src2_o, ctrl_o, rd_o, wr_o : registered ALU operands and pass-through fields
//
// Build option: define ALU_OPS_FWD_EN to enable EX/MEM and MEM/WB forwarding. Without it the
// register-file values are used directly and the exmem_*/memwb_* ports are ignored.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CTRL_W = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic              zext_i,
  input  logic              alusrc_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              wr_i,
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              wr_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
    logic              wr;
  } entry_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic accept;
  logic take;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] imm_ext;

`ifdef ALU_OPS_FWD_EN
  // Register 0 is hardwired, so it never picks up an in-flight result.
  // EX/MEM is the younger producer and therefore wins over MEM/WB.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] a,
    input logic [DATA_W-1:0] d,
    input logic              exw,
    input logic [REG_AW-1:0] exrd,
    input logic [DATA_W-1:0] exd,
    input logic              mww,
    input logic [REG_AW-1:0] mwrd,
    input logic [DATA_W-1:0] mwd
  );
    logic [DATA_W-1:0] r;
    r = d;
    if (a != '0) begin
      if (exw && (exrd == a))      r = exd;
      else if (mww && (mwrd == a)) r = mwd;
    end
    return r;
  endfunction

  assign rs_fwd = fwd(rs_addr_i, rs_data_i, exmem_wr_i, exmem_rd_i, exmem_data_i,
                      memwb_wr_i, memwb_rd_i, memwb_data_i);
  assign rt_fwd = fwd(rt_addr_i, rt_data_i, exmem_wr_i, exmem_rd_i, exmem_data_i,
                      memwb_wr_i, memwb_rd_i, memwb_data_i);
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_wr_i, exmem_rd_i, exmem_data_i,
                        memwb_wr_i, memwb_rd_i, memwb_data_i};
  assign rs_fwd = rs_data_i;
  assign rt_fwd = rt_data_i;
`endif

  assign imm_ext = zext_i ? {{(DATA_W-IMM_W){1'b0}}, imm_i}
                          : {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  always_comb begin
    new_entry.src1 = rs_fwd;
    new_entry.src2 = alusrc_i ? imm_ext : rt_fwd;
    new_entry.ctrl = ctrl_i;
    new_entry.rd   = rd_i;
    new_entry.wr   = wr_i;
  end

  assign accept = in_valid_i & in_ready_o;
  assign take   = out_valid_o & out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !take)      state_d = ST_FULL;
          else if (take && !accept) state_d = ST_EMPTY;
        end
        ST_FULL:  if (take) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry data movement. Operands are frozen at capture; nothing is re-forwarded later.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (flush_i) begin
      out_d.rd  = '0;
      out_d.wr  = 1'b0;
      skid_d.rd = '0;
      skid_d.wr = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) out_d = new_entry;
        ST_ONE: begin
          // Output slot frees this edge -> new item goes straight to it; else park in skid.
          if (accept && take) out_d  = new_entry;
          else if (accept)    skid_d = new_entry;
        end
        ST_FULL:  if (take) out_d = skid_q;
        default:  out_d = out_q;
      endcase
    end
  end

  // Outputs, all derived from registered state
  always_comb begin
    out_valid_o = (state_q != ST_EMPTY);
    in_ready_o  = (state_q != ST_FULL);
    src1_o      = out_q.src1;
    src2_o      = out_q.src2;
    ctrl_o      = out_q.ctrl;
    rd_o        = out_q.rd;
    wr_o        = out_q.wr;
  end

endmodule
